// File: rtl/ram64_pkg.sv
// rtl/ram64_pkg.sv - shared widths and helpers for the ram64 memory slice
package ram64_pkg;
  localparam int WORD_W      = 16;
  localparam int ADDR_W      = 6;
  localparam int BANK_ADDR_W = 3;
  localparam int BANKS       = 8;
  localparam int BANK_WORDS  = 1 << BANK_ADDR_W;

  typedef logic [WORD_W-1:0]             word_t;
  typedef logic [ADDR_W-1:0]             addr_t;
  typedef logic [ADDR_W-BANK_ADDR_W-1:0] bank_sel_t;
  typedef logic [BANK_ADDR_W-1:0]        bank_addr_t;

  // Upper address bits pick the bank, lower bits the word inside it.
  function automatic bank_sel_t bank_of(addr_t a);
    return a[ADDR_W-1:BANK_ADDR_W];
  endfunction

  function automatic bank_addr_t word_of(addr_t a);
    return a[BANK_ADDR_W-1:0];
  endfunction
endpackage

// File: rtl/ram64_ram8.sv
// rtl/ram64_ram8.sv - 8-word bank with combinational read and clocked write
module ram8
  import ram64_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  word_t      in,
  input  logic       load,
  input  bank_addr_t address,
  output word_t      out
);

  word_t mem [BANK_WORDS];

  // Reset wins over load, so a reset cycle never commits a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BANK_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (load) begin
      mem[address] <= in;
    end
  end

  assign out = mem[address];

endmodule

// File: rtl/ram64.sv
// rtl/ram64.sv - 64-word memory built from eight ram8 banks
module ram64
  import ram64_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  word_t in,
  input  logic  load,
  input  addr_t address,
  output word_t out
);

  bank_sel_t        sel;
  bank_addr_t       word_addr;
  logic [BANKS-1:0] bank_load;
  word_t            bank_out [BANKS];

  assign sel       = bank_of(address);
  assign word_addr = word_of(address);

  always_comb begin
    bank_load      = '0;
    bank_load[sel] = load;
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    ram8 u_bank (
      .clk     (clk),
      .reset   (reset),
      .in      (in),
      .load    (bank_load[b]),
      .address (word_addr),
      .out     (bank_out[b])
    );
  end

  assign out = bank_out[sel];

endmodule

// File: tb/tb_ram64.sv
// tb/tb_ram64.sv - self-checking bench for ram64 against an array reference
module tb_ram64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in = '0;
  logic        load = 1'b0;
  logic [5:0]  address = '0;
  logic [15:0] out;

  logic [15:0] model [64];
  int compared = 0;
  int mismatched = 0;

  ram64 dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] exp);
    compared++;
    assert (out === exp)
    else begin
      mismatched++;
      $error("FAIL %s addr=%0d observed=%h expected=%h", tag, address, out, exp);
    end
  endtask

  task automatic read_check(input string tag, input logic [5:0] a);
    address = a;
    #1;
    check(tag, model[a]);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model[i] = 16'h0000;
  endtask

  // One edge with the given controls; model follows the behavioural rules.
  task automatic step(input logic r, input logic ld, input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    reset = r; load = ld; address = a; in = d;
    @(posedge clk);
    #1;
    if (r) model_clear();
    else if (ld) model[a] = d;
    reset = 1'b0; load = 1'b0;
  endtask

  logic [5:0]  wa [7] = '{6'd1, 6'd8, 6'd10, 6'd25, 6'd37, 6'd48, 6'd63};
  logic [15:0] wd [7] = '{16'h0001, 16'h2008, 16'h300a, 16'h4025, 16'h5037, 16'h6048, 16'h7063};

  initial begin
    step(1'b1, 1'b0, 6'd0, 16'h0000);
    for (int i = 0; i < 64; i++) read_check("reset_sweep", 6'(i));

    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, wa[i], wd[i]);
    for (int i = 0; i < 7; i++) begin
      address = wa[i];
      #1;
      check("write_across_banks", wd[i]);
    end
    address = 6'd21;
    #1;
    check("unwritten_21", 16'h0000);

    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 6'd10, 16'hFFFF);
    address = 6'd10;
    #1;
    check("write_inhibit", 16'h300a);

    @(negedge clk);
    address = 6'd5; in = 16'hABCD; load = 1'b1;
    #1;
    check("rdw_before_edge", 16'h0000);
    @(posedge clk);
    #1;
    load = 1'b0;
    model[5] = 16'hABCD;
    check("rdw_after_edge", 16'hABCD);
    read_check("rdw_neighbour_4", 6'd4);
    read_check("rdw_neighbour_13", 6'd13);

    step(1'b1, 1'b1, 6'd63, 16'h1234);
    address = 6'd63;
    #1;
    check("reset_priority_63", 16'h0000);
    for (int i = 0; i < 7; i++) begin
      address = wa[i];
      #1;
      check("reset_clears_written", 16'h0000);
    end
    address = 6'd5;
    #1;
    check("reset_clears_5", 16'h0000);

    step(1'b0, 1'b1, 6'd7, 16'hAAAA);
    step(1'b0, 1'b1, 6'd8, 16'h5555);
    address = 6'd7;
    #1;
    check("bank_boundary_7", 16'hAAAA);
    address = 6'd8;
    #1;
    check("bank_boundary_8", 16'h5555);

    for (int n = 0; n < 300; n++) begin
      logic [5:0]  a;
      logic [15:0] d;
      logic        ld;
      logic        r;
      a  = 6'($urandom_range(0, 63));
      d  = 16'($urandom);
      ld = 1'($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 49) == 0);
      step(r, ld, a, d);
      read_check("random_written", a);
      read_check("random_other", 6'($urandom_range(0, 63)));
    end

    for (int i = 0; i < 64; i++) read_check("final_sweep", 6'(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
